// File: rtl/output_packer_pkg.sv
// Shared configuration and packed-word layout for the output packer and its FIFO.
package output_packer_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_FM_WIDTH     = 128;
    localparam int DEF_FM_HEIGHT    = 128;
    localparam int DEF_OUT_CHANNELS = 64;
    localparam int PACK_DEFAULT       = 4;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        int data_width;
        int fm_width;
        int fm_height;
        int out_channels;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        data_width:   DEF_DATA_WIDTH,
        fm_width:     DEF_FM_WIDTH,
        fm_height:    DEF_FM_HEIGHT,
        out_channels: DEF_OUT_CHANNELS
    };

    localparam int DEF_IDX_W  = $clog2(DEF_FM_WIDTH * DEF_FM_HEIGHT * DEF_OUT_CHANNELS);
    localparam int DEF_ADDR_W = DEF_IDX_W - $clog2(PACK_DEFAULT);

    // Word layout at the default configuration; the top re-declares it at its own widths.
    typedef struct packed {
        logic [PACK_DEFAULT-1:0][DEF_DATA_WIDTH-1:0] data;
        logic [DEF_ADDR_W-1:0]                       addr;
        logic [PACK_DEFAULT-1:0]                     strb;
    } word_t;

endpackage

// File: rtl/output_packer_fifo_fwft.sv
// Registered first-word-fall-through FIFO; the head entry is visible whenever not empty.
module fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/output_packer.sv
// Packs the convolution core's unthrottled sample stream into PACK-lane words,
// buffers them and presents them on a valid/ready write port with lane strobes.
module output_packer
    import output_packer_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int PACK               = PACK_DEFAULT,
    parameter int FIFO_DEPTH         = FIFO_DEPTH_DEFAULT,
    parameter int FEATURE_MAP_WIDTH  = DEF_FM_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FM_HEIGHT,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUT_CHANNELS,
    localparam int IDX_W  = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS),
    localparam int LANE_W = $clog2(PACK),
    localparam int ADDR_W = IDX_W - LANE_W,
    localparam int XW     = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW     = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CW     = $clog2(OUTPUT_NB_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         out_valid,
    input  logic [XW-1:0]                out_x,
    input  logic [YW-1:0]                out_y,
    input  logic [CW-1:0]                out_ch,
    input  logic                         flush,
    output logic [PACK*DATA_WIDTH-1:0]   wr_data,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [PACK-1:0]              wr_strb,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic                         overflow,
    output logic                         idle
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] OPEN  = 1'b1;

    typedef struct packed {
        logic [PACK-1:0][DATA_WIDTH-1:0] data;
        logic [ADDR_W-1:0]               addr;
        logic [PACK-1:0]                 strb;
    } pword_t;

    logic [0:0]          state_q;
    pword_t              word_q;
    logic                pend_q;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   waddr;
    logic [LANE_W-1:0]   lane;
    logic                s_open;
    pword_t              s_word;
    logic                first_vld;
    pword_t              first_word;
    logic                close;
    logic                push;
    pword_t              push_word;
    logic                nxt_open;
    logic                nxt_pend;
    logic                pop;
    logic                full;
    logic                empty;
    logic [$bits(pword_t)-1:0] head_raw;
    pword_t              head;

    assign idx   = (IDX_W'(out_ch) * IDX_W'(FEATURE_MAP_HEIGHT) + IDX_W'(out_y))
                   * IDX_W'(FEATURE_MAP_WIDTH) + IDX_W'(out_x);
    assign waddr = idx[IDX_W-1:LANE_W];
    assign lane  = idx[LANE_W-1:0];

    // Pushes are ordered: pending word, then a broken word, then the word this
    // cycle closes. Only the first of these goes out; a second waits in pend_q.
    always_comb begin
        s_open     = (state_q == OPEN) && !pend_q;
        s_word     = word_q;
        first_vld  = pend_q;
        first_word = word_q;
        if (out_valid) begin
            if (s_open && (waddr != s_word.addr)) begin
                first_vld  = 1'b1;
                first_word = s_word;
                s_open     = 1'b0;
            end
            if (!s_open) begin
                s_word.addr = waddr;
                s_word.strb = '0;
            end
            s_word.data[lane] = out_data;
            s_word.strb[lane] = 1'b1;
            s_open            = 1'b1;
        end
        close     = s_open && ((out_valid && (lane == LANE_W'(PACK-1))) || flush);
        push      = first_vld || close;
        push_word = first_vld ? first_word : s_word;
        nxt_open  = s_open && !(close && !first_vld);
        nxt_pend  = close && first_vld;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= EMPTY;
            word_q   <= '0;
            pend_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= nxt_open ? OPEN : EMPTY;
            word_q  <= s_word;
            pend_q  <= nxt_pend;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    fifo_fwft #(
        .WIDTH ($bits(pword_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (full),
        .empty     (empty)
    );

    assign head     = empty ? '0 : pword_t'(head_raw);
    assign wr_valid = !empty;
    assign wr_data  = head.data;
    assign wr_addr  = head.addr;
    assign wr_strb  = head.strb;
    assign pop      = wr_valid && wr_ready;
    assign idle     = (state_q == EMPTY) && empty && !pend_q;

endmodule

// File: doc/output_packer.md
Name: output_packer

Overview:
- Sits directly downstream of the convolution core and consumes its unthrottled output stream (output_data, output_valid, output_x/y/ch).
- Computes a linear index for each sample, packs samples into PACK-lane words and buffers them in a small FIFO.
- Presents the words to external memory over a valid/ready write port with a per-lane strobe.
- The core has no backpressure, so this block absorbs stalls and flags any words it loses.

Parameters:
- DATA_WIDTH, 16: width of one output sample.
- PACK, 4: samples per packed word; power of two, at least 2.
- FIFO_DEPTH, 8: packed-word FIFO entries; power of two.
- FEATURE_MAP_WIDTH, 128: x extent.
- FEATURE_MAP_HEIGHT, 128: y extent.
- OUTPUT_NB_CHANNELS, 64: ch extent.
- Derived: IDX_W = clog2(W*H*C); ADDR_W = IDX_W - clog2(PACK).

Ports:
- clk, in, 1: clock.
- arst_n, in, 1: asynchronous active-low reset.
- out_data, in, DATA_WIDTH: signed sample from the core.
- out_valid, in, 1: sample valid; there is no ready signal.
- out_x, in, clog2(FEATURE_MAP_WIDTH): x coordinate.
- out_y, in, clog2(FEATURE_MAP_HEIGHT): y coordinate.
- out_ch, in, clog2(OUTPUT_NB_CHANNELS): channel.
- flush, in, 1: single-cycle request to emit the open partial word; tied to fsm_done.
- wr_data, out, PACK*DATA_WIDTH: packed word; lane k occupies bits [k*DW +: DW].
- wr_addr, out, ADDR_W: word address.
- wr_strb, out, PACK: lane-written mask.
- wr_valid, out, 1: word available.
- wr_ready, in, 1: sink accepts the word.
- overflow, out, 1: sticky; a word was dropped.
- idle, out, 1: no open word, FIFO empty, no flush pending.

Behaviour:
- Reset (async, arst_n=0):
  - wr_valid=0, wr_data=0, wr_addr=0, wr_strb=0, overflow=0, idle=1.
  - FIFO emptied, open word discarded, flush_pending=0.
  - Reset mid-operation loses all buffered data; no partial write is ever emitted.
- Index arithmetic:
  - idx = (ch*H + y)*W + x, computed at IDX_W bits with no truncation.
  - waddr = idx >> log2(PACK); lane = idx[log2(PACK)-1:0].
- Packer state: open (1b), cur_addr, lane regs, strb. It has two states, EMPTY and OPEN.
- Sample handling, on out_valid:
  - EMPTY: open a word at waddr and write the lane; strb = 1<<lane.
  - OPEN with waddr == cur_addr: write the lane. A duplicate lane overwrites the data; strb is unchanged.
  - OPEN with waddr != cur_addr (break): push the old word, then open a new word with this sample.
  - Writing lane PACK-1 with strb then all-ones: push in the same cycle and return to EMPTY.
  - Writing lane PACK-1 with strb not all-ones: also push, so the word is emitted with a partial strobe.
- At most one FIFO push per cycle.
  - If a cycle needs two pushes, push the first and carry the second into the next cycle via flush_pending. Cases: a break sample that also lands on lane PACK-1, or flush on a break cycle.
  - out_valid may arrive in the cycle that resolves flush_pending. The pending word is pushed first; the new sample then follows the normal rules against EMPTY.
- Flush:
  - With an open word and no other push this cycle: push now and go to EMPTY.
  - Otherwise set flush_pending.
  - Flush while EMPTY and nothing pending: no effect.
- FIFO:
  - Registered, first-word-fall-through.
  - A push at edge t makes wr_valid=1 from cycle t+1 when the FIFO was empty.
  - A pop occurs on wr_valid && wr_ready.
  - A push and a pop in the same cycle when full are allowed; count is unchanged.
  - A push when full with no pop: the word is dropped and overflow is set until reset.
  - While wr_valid && !wr_ready, wr_data, wr_addr and wr_strb must stay stable.
- Latency:
  - The sample completing a word at cycle t appears on the write port at t+1 when the FIFO is empty.
  - A break-triggered word appears at t+1 after the break cycle.
- idle: combinational from registered state.

Decomposition:
- Shared package holds:
  - config_t fields used here (DATA_WIDTH, FEATURE_MAP_*, OUTPUT_NB_CHANNELS);
  - the packed-word struct (data, addr, strb);
  - the PACK and FIFO_DEPTH defaults.
- One natural sub-module: fifo_fwft, generic over a type or width and depth, exposing full, empty, push, pop.
- The packer FSM and index arithmetic stay in output_packer.

Test Plan:
- Aligned 4-sample run: W=8, H=8, C=4, wr_ready=1; samples idx 0..3 with values 1..4 on consecutive cycles → one word, addr 0, strb 4'b1111, data {4,3,2,1}, wr_valid on the cycle after the 4th sample.
- Partial word plus flush: idx 8 and 9 (values 7, 9), then flush → addr 2, strb 4'b0011, lanes 2–3 unspecified, idle=1 two cycles later.
- Break: idx 5 then idx 12 → first word addr 1, strb 4'b0010; then flush → second word addr 3, strb 4'b0001; exactly 2 writes.
- Duplicate lane: idx 0 with value 3, then idx 0 with value 5, then idx 1..3 → one word, lane0 = 5, strb 4'b1111.
- Backpressure overflow: wr_ready=0, stream 40 consecutive samples (10 words), FIFO_DEPTH=8 → overflow rises on the push of word 9. Then release wr_ready → exactly 8 words drain, addresses 0..7, stable while stalled.
- Reset mid-operation: 2 samples open, assert arst_n=0 for one cycle → wr_valid=0 and idle=1 immediately; after release, a flush produces no write.
